ctrl_bubble_pipe: RTL

//  Carries decoded control words from ID through the EX/MEM/WB control registers. Injects

---
 rtl/ctrl_pipe_pkg.sv | 24 ++
 rtl/ctrl_stage_reg.sv | 28 ++
 rtl/ctrl_bubble_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-word pipeline: word layout, bubble word and FSM states.
package ctrl_pipe_pkg;
  localparam int CTRL_CW     = 13;

  // Field layout, LSB first: dmem_en, size, rw, s_bit, bl, load, alu_op[3:0], rf_en, am[1:0]
  localparam int DMEM_EN_BIT = 0;
  localparam int SIZE_BIT    = 1;
  localparam int RW_BIT      = 2;
  localparam int S_BIT       = 3;
  localparam int BL_BIT      = 4;
  localparam int LOAD_BIT    = 5;
  localparam int ALU_OP_LSB  = 6;
  localparam int ALU_OP_W    = 4;
  localparam int RF_EN_BIT   = 10;
  localparam int AM_LSB      = 11;
  localparam int AM_W        = 2;

  localparam logic [CTRL_CW-1:0] BUBBLE_WORD_DEF = '0;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } pipe_state_e;
endpackage

// File: rtl/ctrl_stage_reg.sv
// One control pipeline stage: {valid, word} register with async clear, sync clear and load.
module ctrl_stage_reg #(
  parameter int                 DATA_W   = 14,
  parameter logic [DATA_W-1:0]  CLR_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              sclr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= CLR_WORD;
    end else if (sclr_i) begin
      q_q <= CLR_WORD;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ctrl_bubble_pipe.sv
// EX/MEM/WB control-word pipeline with programmable stall bubbles, branch flush and bubble statistics.
module ctrl_bubble_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                 CW          = CTRL_CW,
  parameter int                 STAGES      = 3,
  parameter int                 MAX_STALL   = 3,
  parameter logic [CW-1:0]      BUBBLE_WORD = CW'(BUBBLE_WORD_DEF),
  parameter logic [STAGES-1:0]  FLUSH_MASK  = STAGES'(1),
  parameter int                 SCW         = $clog2(MAX_STALL + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CW-1:0]        ctrl_in,
  input  logic                 valid_in,
  input  logic                 stall_req,
  input  logic [SCW-1:0]       stall_cycles,
  input  logic                 flush_req,
  output logic [STAGES*CW-1:0] ctrl_out,
  output logic [STAGES-1:0]    valid_out,
  output logic                 hold_front,
  output logic [15:0]          bubble_cnt
);

  localparam logic [SCW-1:0] MAX_N = SCW'(MAX_STALL);

  pipe_state_e    state_q;
  logic [SCW-1:0] cnt_q;
  logic [SCW-1:0] stall_n;
  logic [15:0]    bubble_cnt_q;
  logic [15:0]    bubble_cnt_d;
  logic           stall_start;
  logic           bubble_now;
  logic [CW:0]    stage_q [STAGES];

  assign stall_n     = (stall_cycles > MAX_N) ? MAX_N : stall_cycles;
  assign stall_start = (state_q == RUN) && stall_req && (stall_cycles != '0);
  // Flush wins over any stall, so it also releases the front end in the same cycle.
  assign bubble_now  = !flush_req && (stall_start || (state_q == BUBBLE));
  assign hold_front  = bubble_now;

  assign bubble_cnt_d = (bubble_now && (bubble_cnt_q != 16'hFFFF)) ? bubble_cnt_q + 16'd1
                                                                    : bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      if (flush_req) begin
        state_q <= RUN;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          RUN: begin
            if (stall_start && (stall_n > SCW'(1))) begin
              cnt_q   <= stall_n - SCW'(1);
              state_q <= BUBBLE;
            end
          end
          BUBBLE: begin
            cnt_q <= cnt_q - SCW'(1);
            if (cnt_q == SCW'(1)) state_q <= RUN;
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [CW:0] d;
    logic        sclr;

    if (i == 0) begin : g_head
      assign d    = {valid_in, ctrl_in};
      assign sclr = flush_req | bubble_now;
    end else begin : g_tail
      assign d    = stage_q[i-1];
      assign sclr = flush_req & FLUSH_MASK[i];
    end

    ctrl_stage_reg #(
      .DATA_W   (CW + 1),
      .CLR_WORD ({1'b0, BUBBLE_WORD})
    ) u_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (1'b1),
      .sclr_i (sclr),
      .d_i    (d),
      .q_o    (stage_q[i])
    );

    assign ctrl_out[i*CW +: CW] = stage_q[i][CW-1:0];
    assign valid_out[i]         = stage_q[i][CW];
  end

endmodule
